id_stage: RTL and testbench

Instruction-decode stage of the single-issue RV32I core, directly downstream of the fetch unit. It captures the fetched `Instruction_Code` and its PC into the IF/ID boundary. It decodes fields and immediates, reads two operands from an internal 32x32 register file, and presents one registered decode bundle per cycle to the execute stage. It also owns the register-file write port, driven by write-back.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/reg_file.sv | 43 ++++
 rtl/id_stage.sv | 157 +++++++++++++++
 tb/tb_id_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, operation classes and ALU codes.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;
  localparam logic [6:0] OpcodeJal    = 7'b1101111;
  localparam logic [6:0] OpcodeLui    = 7'b0110111;

  typedef enum logic [2:0] {
    OpAluR    = 3'd0,
    OpAluI    = 3'd1,
    OpLoad    = 3'd2,
    OpStore   = 3'd3,
    OpBranch  = 3'd4,
    OpJal     = 3'd5,
    OpLui     = 3'd6,
    OpIllegal = 3'd7
  } op_class_e;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b1000;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one synchronous write port, synchronous active-low clear.
module reg_file #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem_q [NREG];
  logic            wr_active;

  assign wr_active = we && (waddr != 5'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_active) begin
      mem_q[waddr] <= wdata;
    end
  end

  // x0 reads as zero regardless of array contents; a same-cycle write wins.
  always_comb begin
    rdata1 = mem_q[raddr1];
    rdata2 = mem_q[raddr2];
    if (wr_active && waddr == raddr1) rdata1 = wdata;
    if (wr_active && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: IF/ID capture, field/immediate decode,
// operand read from the internal register file and a registered decode bundle.
module id_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned NREG = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     Instruction_Code,
  input  logic [XLEN-1:0] if_pc,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [31:0]     imm,
  output logic [4:0]      rd,
  output logic [2:0]      op_class,
  output logic [3:0]      alu_op,
  output logic            reg_write,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = Instruction_Code[6:0];
  assign funct3 = Instruction_Code[14:12];
  assign imm_i  = {{20{Instruction_Code[31]}}, Instruction_Code[31:20]};
  assign imm_s  = {{20{Instruction_Code[31]}}, Instruction_Code[31:25], Instruction_Code[11:7]};
  assign imm_b  = {{19{Instruction_Code[31]}}, Instruction_Code[31], Instruction_Code[7],
                   Instruction_Code[30:25], Instruction_Code[11:8], 1'b0};
  assign imm_u  = {Instruction_Code[31:12], 12'b0};
  assign imm_j  = {{11{Instruction_Code[31]}}, Instruction_Code[31], Instruction_Code[19:12],
                   Instruction_Code[20], Instruction_Code[30:21], 1'b0};

  op_class_e   class_d;
  logic [31:0] imm_d;
  logic [3:0]  alu_d;
  logic        writes_rd;
  logic        illegal_d;

  always_comb begin
    class_d   = OpIllegal;
    imm_d     = '0;
    alu_d     = AluAdd;
    writes_rd = 1'b0;
    illegal_d = 1'b0;
    case (opcode)
      OpcodeOp: begin
        class_d   = OpAluR;
        alu_d     = {Instruction_Code[30], funct3};
        writes_rd = 1'b1;
      end
      OpcodeOpImm: begin
        class_d   = OpAluI;
        imm_d     = imm_i;
        // Only shifts-right use funct7[5] (SRAI); other I-type ops keep it clear.
        alu_d     = {Instruction_Code[30] & (funct3 == 3'b101), funct3};
        writes_rd = 1'b1;
      end
      OpcodeLoad: begin
        class_d   = OpLoad;
        imm_d     = imm_i;
        writes_rd = 1'b1;
      end
      OpcodeStore: begin
        class_d = OpStore;
        imm_d   = imm_s;
      end
      OpcodeBranch: begin
        class_d = OpBranch;
        imm_d   = imm_b;
        alu_d   = AluSub;
      end
      OpcodeJal: begin
        class_d   = OpJal;
        imm_d     = imm_j;
        writes_rd = 1'b1;
      end
      OpcodeLui: begin
        class_d   = OpLui;
        imm_d     = imm_u;
        writes_rd = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  logic [4:0]      rs1_idx_q, rs2_idx_q;
  logic [4:0]      rs1_idx, rs2_idx;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;

  // During a stall the held indices keep re-reading so write-back stays visible.
  assign rs1_idx = stall ? rs1_idx_q : Instruction_Code[19:15];
  assign rs2_idx = stall ? rs2_idx_q : Instruction_Code[24:20];

  reg_file #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_reg_file (
    .clock  (clock),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      id_valid  <= 1'b0;
      id_pc     <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      imm       <= '0;
      rd        <= '0;
      op_class  <= OpAluR;
      alu_op    <= '0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
    end else begin
      if (flush) begin
        id_valid <= 1'b0;
      end else if (!stall) begin
        id_valid <= if_valid;
      end
      if (!stall) begin
        id_pc     <= if_pc;
        imm       <= imm_d;
        rd        <= Instruction_Code[11:7];
        op_class  <= class_d;
        alu_op    <= alu_d;
        reg_write <= writes_rd && (Instruction_Code[11:7] != 5'd0);
        illegal   <= illegal_d;
        rs1_idx_q <= Instruction_Code[19:15];
        rs2_idx_q <= Instruction_Code[24:20];
      end
      rs1_data <= rf_rdata1;
      rs2_data <= rf_rdata2;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed plus randomized bench for id_stage against a behavioural decode and
// register-file model.
module tb_id_stage;

  logic        clock;
  logic        reset;
  logic        if_valid;
  logic [31:0] Instruction_Code;
  logic [31:0] if_pc;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [2:0]  op_class;
  logic [3:0]  alu_op;
  logic        reg_write;
  logic        illegal;

  id_stage dut (
    .clock            (clock),
    .reset            (reset),
    .if_valid         (if_valid),
    .Instruction_Code (Instruction_Code),
    .if_pc            (if_pc),
    .stall            (stall),
    .flush            (flush),
    .wb_en            (wb_en),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .imm              (imm),
    .rd               (rd),
    .op_class         (op_class),
    .alu_op           (alu_op),
    .reg_write        (reg_write),
    .illegal          (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Operation classes in the order the decode bundle defines them.
  localparam int ClsAluR = 0, ClsAluI = 1, ClsLoad = 2, ClsStore = 3;
  localparam int ClsBranch = 4, ClsJal = 5, ClsLui = 6, ClsIllegal = 7;

  typedef struct packed {
    logic [2:0]  cls;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        rw;
    logic        ill;
  } dec_t;

  // Model state
  logic [31:0] m_regs [32];
  logic [31:0] m_ins;
  logic        m_valid;
  logic [31:0] m_pc, m_r1, m_r2;
  dec_t        m_dec;

  function automatic dec_t ref_decode(logic [31:0] ins);
    dec_t d;
    int   sgn;
    int   f3;
    int   rdi;
    sgn = ins[31] ? -1 : 0;
    f3  = int'(ins[14:12]);
    rdi = int'(ins[11:7]);
    d   = '0;
    d.cls = 3'(ClsIllegal);
    case (ins[6:0])
      7'h33: begin d.cls = 3'(ClsAluR); d.alu = 4'(int'(ins[30]) * 8 + f3); d.rw = 1'b1; end
      7'h13: begin
        d.cls = 3'(ClsAluI);
        d.imm = 32'(sgn * 2048 + int'(ins[30:20]));
        d.alu = 4'(((f3 == 5 && ins[30]) ? 8 : 0) + f3);
        d.rw  = 1'b1;
      end
      7'h03: begin d.cls = 3'(ClsLoad); d.imm = 32'(sgn * 2048 + int'(ins[30:20])); d.rw = 1'b1; end
      7'h23: begin d.cls = 3'(ClsStore); d.imm = 32'(sgn * 2048 + int'(ins[30:25]) * 32 + rdi); end
      7'h63: begin
        d.cls = 3'(ClsBranch);
        d.imm = 32'(sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                    + int'(ins[11:8]) * 2);
        d.alu = 4'd8;
      end
      7'h6F: begin
        d.cls = 3'(ClsJal);
        d.imm = 32'(sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                    + int'(ins[30:21]) * 2);
        d.rw  = 1'b1;
      end
      7'h37: begin d.cls = 3'(ClsLui); d.imm = ins & 32'hFFFF_F000; d.rw = 1'b1; end
      default: d.ill = 1'b1;
    endcase
    if (rdi == 0) d.rw = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] ref_read(logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  task automatic model_step();
    logic [31:0] src;
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_ins = 32'd0; m_valid = 1'b0; m_pc = 32'd0; m_r1 = 32'd0; m_r2 = 32'd0;
      m_dec = '0;
    end else begin
      src  = stall ? m_ins : Instruction_Code;
      m_r1 = ref_read(src[19:15]);
      m_r2 = ref_read(src[24:20]);
      if (flush) m_valid = 1'b0;
      else if (!stall) m_valid = if_valid;
      if (!stall) begin
        m_ins = Instruction_Code;
        m_pc  = if_pc;
        m_dec = ref_decode(Instruction_Code);
      end
      if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("id_valid", 32'(id_valid), 32'(m_valid));
    check("id_pc", id_pc, m_pc);
    check("rs1_data", rs1_data, m_r1);
    check("rs2_data", rs2_data, m_r2);
    check("imm", imm, m_dec.imm);
    check("rd", 32'(rd), 32'(m_ins[11:7]));
    check("op_class", 32'(op_class), 32'(m_dec.cls));
    check("alu_op", 32'(alu_op), 32'(m_dec.alu));
    check("reg_write", 32'(reg_write), 32'(m_dec.rw));
    check("illegal", 32'(illegal), 32'(m_dec.ill));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic drive(logic v, logic [31:0] ins, logic [31:0] pc, logic st, logic fl,
                       logic we, logic [4:0] wr, logic [31:0] wd);
    if_valid = v; Instruction_Code = ins; if_pc = pc; stall = st; flush = fl;
    wb_en = we; wb_rd = wr; wb_data = wd;
  endtask

  logic [6:0] opcodes [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    int          k;

    // Reset for two cycles.
    reset = 1'b0;
    drive(1'b1, 32'h0020_8133, 32'h100, 1'b0, 1'b0, 1'b1, 5'd4, 32'h55);
    tick();
    tick();
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_class", 32'(op_class), 32'd0);
    reset = 1'b1;

    // Write x1 = 5, then add x2,x1,x2.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5);
    tick();
    drive(1'b1, 32'h0020_8133, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    check("add_rs1", rs1_data, 32'd5);
    check("add_rs2", rs2_data, 32'd0);
    check("add_alu", 32'(alu_op), 32'd0);
    check("add_rw", 32'(reg_write), 32'd1);
    check("add_rd", 32'(rd), 32'd2);

    drive(1'b1, 32'h0020_A423, 32'h204, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    check("sw_class", 32'(op_class), 32'(ClsStore));
    check("sw_imm", imm, 32'd8);
    check("sw_rw", 32'(reg_write), 32'd0);

    drive(1'b1, 32'hFE00_0EE3, 32'h208, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    check("beq_class", 32'(op_class), 32'(ClsBranch));
    check("beq_imm", imm, 32'hFFFF_FFFC);
    check("beq_alu", 32'(alu_op), 32'b1000);

    drive(1'b1, 32'h1234_52B7, 32'h20C, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    check("lui_imm", imm, 32'h1234_5000);

    // Bypass: write x3 in the same cycle addi x1,x3,0 is captured.
    drive(1'b1, 32'h0001_8093, 32'h210, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    tick();
    check("bypass_rs1", rs1_data, 32'hDEAD_BEEF);

    // Stall three cycles while x1 becomes 7.
    drive(1'b1, 32'h0020_8133, 32'h214, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b1, 32'h0001_8093, 32'h218, 1'b1, 1'b0, 1'b1, 5'd1, 32'd7);
    tick();
    drive(1'b1, 32'h0001_8093, 32'h218, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    check("stall_pc", id_pc, 32'h214);
    check("stall_rs1", rs1_data, 32'd7);
    check("stall_valid", 32'(id_valid), 32'd1);

    // Stall and flush together.
    drive(1'b1, 32'h0001_8093, 32'h218, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    check("flush_valid", 32'(id_valid), 32'd0);

    drive(1'b1, 32'hFFFF_FFFF, 32'h21C, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_rw", 32'(reg_write), 32'd0);
    check("ill_valid", 32'(id_valid), 32'd1);

    // Write to x0 is ignored.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd9);
    tick();
    drive(1'b1, 32'h0000_0133, 32'h220, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    check("x0_rs1", rs1_data, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 7));
      r = $urandom();
      ins = (k == 7) ? r : {r[31:7], opcodes[k]};
      reset = ($urandom_range(0, 49) != 0);
      r = $urandom();
      drive(r[0], ins, $urandom(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            r[1], r[6:2], $urandom());
      tick();
    end
    reset = 1'b1;

    // Reset while stalled with a valid bundle.
    drive(1'b1, 32'h0020_8133, 32'h300, 1'b0, 1'b0, 1'b1, 5'd1, 32'd11);
    tick();
    drive(1'b1, 32'h0020_8133, 32'h304, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    check("pre_rst_valid", 32'(id_valid), 32'd1);
    reset = 1'b0;
    drive(1'b1, 32'h0020_8133, 32'h304, 1'b1, 1'b1, 1'b1, 5'd1, 32'd13);
    tick();
    check("mid_rst_valid", 32'(id_valid), 32'd0);
    check("mid_rst_pc", id_pc, 32'd0);
    check("mid_rst_rs1", rs1_data, 32'd0);
    reset = 1'b1;
    drive(1'b1, 32'h0020_8133, 32'h308, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    check("post_rst_x1", rs1_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
